csr_regfile: RTL
================

// Module: csr_regfile
// PURPOSE
//   Machine-mode CSR register file; responder to the execute stage's CSR traffic.
//   Serves csr_rdata_o to the functional unit combinationally.
//   Commits csr_wdata via a valid/ready handshake and handles ecall/mret side effects.
//   Issues a one-cycle registered redirect (trap entry / return PC) to fetch.
// PARAMETERS
//   XLEN      32      data width of CSRs and PC
// PORTS
//   clock        in   1     single clock; all state updates on rising edge
//   reset        in   1     asynchronous, active-low (reset==0 clears state immediately)
//   csr_raddr_i  in   12    CSR address being read by execute
//   csr_rdata_o  out  XLEN  combinational read data for csr_raddr_i
//   valid_i      in   1     execute presents a committing CSR/system op
//   ready_o      out  1     csr_regfile can accept; 0 in REDIRECT state
//   csr_we_i     in   1     op writes csr_waddr_i (qualified by valid_i&ready_o)
//   csr_waddr_i  in   12    CSR write address
//   csr_wdata_i  in   XLEN  write data from functional unit
//   ecall_i      in   1     op is ecall
//   mret_i       in   1     op is mret
//   pc_i         in   XLEN  PC of the committing op
//   redirect_o   out  1     one-cycle pulse: fetch must jump to redirect_pc_o
//   redirect_pc_o out XLEN  trap vector (ecall) or mepc (mret)
//   illegal_o    out  1     comb: valid_i & access to unimplemented CSR address
// BEHAVIOUR
//   Implemented CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342,
//   mcycle 0xB00 (low 32), mcycleh 0xB80 (high 32). Others read 0, writes dropped.
//   Reset values: mstatus=0x0000_1800 (MPP=11), mtvec=0, mepc=0, mcause=0,
//   mcycle=0; redirect_o=0, redirect_pc_o=0, state=IDLE, ready_o=1.
//   Accept = valid_i & ready_o. Nothing commits without Accept.
//   Write rules: mtvec[1:0] and mepc[1:0] forced 00; mstatus writable bits
//   MIE[3], MPIE[7] only, MPP[12:11] hard-wired 11; mcause fully writable.
//   Read is combinational from current state (no same-cycle write bypass).
//   mcycle: 64-bit, +1 every cycle out of reset, wraps 0xFFFF_FFFF_FFFF_FFFF->0.
//   Write to mcycle/mcycleh replaces that half; no increment that cycle.
//   Write to a low half with 0xFFFF_FFFF does not carry (write wins outright).
//   FSM IDLE: ready_o=1. On Accept & ecall_i: mepc<=pc_i&~3, mcause<=11,
//     MPIE<=MIE, MIE<=0, redirect_pc_o<=mtvec, redirect_o<=1, ->REDIRECT.
//   On Accept & mret_i: MIE<=MPIE, MPIE<=1, redirect_pc_o<=mepc,
//     redirect_o<=1, ->REDIRECT. Latency: redirect 1 cycle after Accept.
//   FSM REDIRECT: ready_o=0, redirect_o clears next edge, ->IDLE unconditionally.
//   Priority on simultaneous flags: ecall > mret > csr_we; lower ones discarded.
//   csr_we to an unimplemented address: dropped, illegal_o=1 that cycle, no stall.
//   Reset asserted mid-REDIRECT: outputs to reset values immediately, IDLE.
// TESTING
//   1 Reset release -> mstatus reads 0x1800, mcycle reads 1 after 1 edge, 2 after 2.
//   2 Write mtvec=0x8000_0103 -> read 0x8000_0100; mepc=0x13 -> 0x10.
//   3 mtvec=0x8000_0100, MIE=1, ecall at pc 0x8000_0040 -> next cycle redirect_o=1,
//     redirect_pc_o=0x8000_0100, mepc=0x8000_0040, mcause=11, mstatus=0x1880,
//     ready_o=0 that cycle, 1 the following.
//   4 Then mret -> redirect_pc_o=0x8000_0040, mstatus=0x1888 (MIE=1,MPIE=1).
//   5 Write mcycleh=0, mcycle=0xFFFF_FFFF -> next read mcycleh=1, mcycle=0;
//     force both to all-ones -> wraps to 0.
//   6 ecall+csr_we same Accept -> write discarded; pull reset low during
//     REDIRECT -> redirect_o=0, ready_o=1 asynchronously.

Source files
------------

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: combinational CSR reads, handshaked commits,
// ecall/mret trap sequencing and a one-cycle registered redirect to fetch.
module csr_regfile #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [11:0]     csr_raddr_i,
   output logic [XLEN-1:0] csr_rdata_o,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_waddr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   input  logic            ecall_i,
   input  logic            mret_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            illegal_o
);

   localparam int unsigned CYC_W = 2 * XLEN;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

   localparam int unsigned CAUSE_ECALL_M = 11;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic              mie_q, mie_d;
   logic              mpie_q, mpie_d;
   logic [XLEN-1:0]   mtvec_q, mtvec_d;
   logic [XLEN-1:0]   mepc_q, mepc_d;
   logic [XLEN-1:0]   mcause_q, mcause_d;
   logic [CYC_W-1:0]  mcycle_q, mcycle_d;
   logic              redirect_q, redirect_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

   logic              accept;
   logic [XLEN-1:0]   mstatus_rd;

   function automatic logic is_impl(input logic [11:0] addr);
      return (addr == ADDR_MSTATUS) || (addr == ADDR_MTVEC)  ||
             (addr == ADDR_MEPC)    || (addr == ADDR_MCAUSE) ||
             (addr == ADDR_MCYCLE)  || (addr == ADDR_MCYCLEH);
   endfunction

   assign ready_o       = (state_q == ST_IDLE);
   assign accept        = valid_i & ready_o;
   assign illegal_o     = valid_i & csr_we_i & ~is_impl(csr_waddr_i);
   assign redirect_o    = redirect_q;
   assign redirect_pc_o = redirect_pc_q;

   // mstatus view: MPP hard-wired to machine mode, only MIE/MPIE are stored
   always_comb begin
      mstatus_rd     = '0;
      mstatus_rd[12] = 1'b1;
      mstatus_rd[11] = 1'b1;
      mstatus_rd[7]  = mpie_q;
      mstatus_rd[3]  = mie_q;
   end

   // Read port reflects registered state only; same-cycle writes are not bypassed
   always_comb begin
      csr_rdata_o = '0;
      case (csr_raddr_i)
         ADDR_MSTATUS: csr_rdata_o = mstatus_rd;
         ADDR_MTVEC:   csr_rdata_o = mtvec_q;
         ADDR_MEPC:    csr_rdata_o = mepc_q;
         ADDR_MCAUSE:  csr_rdata_o = mcause_q;
         ADDR_MCYCLE:  csr_rdata_o = mcycle_q[XLEN-1:0];
         ADDR_MCYCLEH: csr_rdata_o = mcycle_q[CYC_W-1:XLEN];
         default:      csr_rdata_o = '0;
      endcase
   end

   // Next-state and commit logic; ecall outranks mret, which outranks a CSR write
   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mtvec_d       = mtvec_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mcycle_d      = mcycle_q + CYC_W'(1);
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (ecall_i) begin
                  mepc_d        = pc_i & ~XLEN'(3);
                  mcause_d      = XLEN'(CAUSE_ECALL_M);
                  mpie_d        = mie_q;
                  mie_d         = 1'b0;
                  redirect_pc_d = mtvec_q;
                  redirect_d    = 1'b1;
                  state_d       = ST_REDIRECT;
               end else if (mret_i) begin
                  mie_d         = mpie_q;
                  mpie_d        = 1'b1;
                  redirect_pc_d = mepc_q;
                  redirect_d    = 1'b1;
                  state_d       = ST_REDIRECT;
               end else if (csr_we_i) begin
                  case (csr_waddr_i)
                     ADDR_MSTATUS: begin
                        mie_d  = csr_wdata_i[3];
                        mpie_d = csr_wdata_i[7];
                     end
                     ADDR_MTVEC:   mtvec_d  = csr_wdata_i & ~XLEN'(3);
                     ADDR_MEPC:    mepc_d   = csr_wdata_i & ~XLEN'(3);
                     ADDR_MCAUSE:  mcause_d = csr_wdata_i;
                     ADDR_MCYCLE:  mcycle_d = {mcycle_q[CYC_W-1:XLEN], csr_wdata_i};
                     ADDR_MCYCLEH: mcycle_d = {csr_wdata_i, mcycle_q[XLEN-1:0]};
                     default: ;
                  endcase
               end
            end
         end
         ST_REDIRECT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mtvec_q       <= '0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mcycle_q      <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mtvec_q       <= mtvec_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mcycle_q      <= mcycle_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

endmodule
